// File: rtl/sdm_pkg.sv
// Shared types and constants for the SDM DAC datapath and its oversampling controller.
package sdm_pkg;

  localparam int SDM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } sdm_osr_state_t;

endpackage

// File: rtl/sdm_sample_fifo.sv
// Small synchronous sample FIFO; head is always presented combinationally.
module sdm_sample_fifo
  import sdm_pkg::*;
#(
  parameter int DATA_W     = SDM_DATA_W,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int LVL_W     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == LVL_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  // A push into a full FIFO is accepted only when the same cycle pops.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sdm_osr_ctrl.sv
// Oversampling sequencer feeding the SDM DAC: buffers PCM samples and strobes each one osr_cfg+1 times.
// Optional build macro SDM_OSR_UNDERRUN_MUTE_EN: an underrun boundary loads mid-scale (0) instead of repeating.
module sdm_osr_ctrl
  import sdm_pkg::*;
#(
  parameter int DATA_W     = SDM_DATA_W,
  parameter int OSR_W      = 8,
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [OSR_W-1:0]  osr_cfg,
  input  logic [DIV_W-1:0]  div_cfg,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              dac_valid,
  output logic [DATA_W-1:0] dac_din,
  output logic              busy,
  output logic              underrun,
  input  logic              clr_underrun,
  output logic [LVL_W-1:0]  fifo_level
);

  sdm_osr_state_t    state;
  logic [OSR_W-1:0]  osr_lat;
  logic [DIV_W-1:0]  div_lat;
  logic [OSR_W-1:0]  osr_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_next;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              start;
  logic              run_mode;
  logic              boundary;
  logic              underrun_evt;

  assign s_ready  = !fifo_full;
  assign push     = s_valid && s_ready;
  assign busy     = (state != IDLE);
  // A FLUSH cycle with en back high behaves exactly like RUN, so resuming leaves no gap.
  assign run_mode = (state == RUN) || ((state == FLUSH) && en);
  // dac_valid is kept equal to (div_cnt == div_lat) while active, so it doubles as the strobe decode.
  assign boundary     = dac_valid && (osr_cnt == osr_lat);
  assign start        = (state == IDLE) && en && !fifo_empty;
  assign pop          = start || (run_mode && boundary && !fifo_empty);
  assign underrun_evt = run_mode && boundary && fifo_empty;
  assign div_next     = (div_cnt == div_lat) ? '0 : div_cnt + 1'b1;

  sdm_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      osr_lat   <= '0;
      div_lat   <= '0;
      osr_cnt   <= '0;
      div_cnt   <= '0;
      dac_valid <= 1'b0;
      dac_din   <= '0;
      underrun  <= 1'b0;
    end else begin
      if (underrun_evt)      underrun <= 1'b1;
      else if (clr_underrun) underrun <= 1'b0;

      case (state)
        IDLE: begin
          dac_valid <= 1'b0;
          if (start) begin
            osr_lat   <= osr_cfg;
            div_lat   <= div_cfg;
            dac_din   <= fifo_head;
            osr_cnt   <= '0;
            div_cnt   <= '0;
            dac_valid <= (div_cfg == '0);
            state     <= RUN;
          end
        end
        RUN, FLUSH: begin
          div_cnt   <= div_next;
          dac_valid <= (div_next == div_lat);
          if (dac_valid) osr_cnt <= boundary ? '0 : osr_cnt + 1'b1;
          if (run_mode) begin
            state <= en ? RUN : FLUSH;
            if (boundary) begin
              if (!fifo_empty) dac_din <= fifo_head;
`ifdef SDM_OSR_UNDERRUN_MUTE_EN
              else             dac_din <= '0;
`endif
            end
          end else if (boundary) begin
            state     <= IDLE;
            dac_valid <= 1'b0;
            osr_cnt   <= '0;
            div_cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdm_osr_ctrl.sv
// Directed testbench for sdm_osr_ctrl with hand-computed strobe timing and sample sequences.
module tb_sdm_osr_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  osr_cfg;
  logic [7:0]  div_cfg;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        dac_valid;
  logic [15:0] dac_din;
  logic        busy;
  logic        underrun;
  logic        clr_underrun;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  logic [15:0] mute_val;

  sdm_osr_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .osr_cfg      (osr_cfg),
    .div_cfg      (div_cfg),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .dac_valid    (dac_valid),
    .dac_din      (dac_din),
    .busy         (busy),
    .underrun     (underrun),
    .clr_underrun (clr_underrun),
    .fifo_level   (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helper only: one accepted push, starting and ending on a falling edge.
  task automatic push_word(input logic [15:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL reset_dac_valid: got %b want 0", dac_valid); end
    checks++; if (dac_din !== 16'h0000) begin errors++; $display("FAIL reset_dac_din: got %h want 0000", dac_din); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic exp_v;
    logic [15:0] exp_d;
    div_cfg = 8'd3; osr_cfg = 8'd1;
    push_word(16'h1000);
    push_word(16'h2000);
    checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL basic_level_pre: got %0d want 2", fifo_level); end
    en = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      exp_v = (n % 4 == 0) && (n <= 16);
      exp_d = (n <= 8) ? 16'h1000 : 16'h2000;
      checks++; if (dac_valid !== exp_v) begin errors++; $display("FAIL basic_valid n=%0d: got %b want %b", n, dac_valid, exp_v); end
      if (exp_v) begin
        checks++; if (dac_din !== exp_d) begin errors++; $display("FAIL basic_din n=%0d: got %h want %h", n, dac_din, exp_d); end
      end
      checks++; if (busy !== (n <= 16)) begin errors++; $display("FAIL basic_busy n=%0d: got %b want %b", n, busy, (n <= 16)); end
      if (n == 1) begin
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL basic_level_n1: got %0d want 1", fifo_level); end
      end
      if (n == 9) begin
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL basic_level_n9: got %0d want 0", fifo_level); end
      end
      if (n == 13) en = 1'b0;
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL basic_underrun: got %b want 0", underrun); end
    checks++; if (dac_din !== 16'h2000) begin errors++; $display("FAIL basic_din_hold: got %h want 2000", dac_din); end
  endtask

  task automatic test_underrun;
    div_cfg = 8'd0; osr_cfg = 8'd0;
    push_word(16'h7FFF);
    en = 1'b1;
    @(negedge clk);
    checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL ur_valid_n1: got %b want 1", dac_valid); end
    checks++; if (dac_din !== 16'h7FFF) begin errors++; $display("FAIL ur_din_n1: got %h want 7fff", dac_din); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_flag_n1: got %b want 0", underrun); end
    @(negedge clk);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_flag_n2: got %b want 1", underrun); end
    checks++; if (dac_din !== mute_val) begin errors++; $display("FAIL ur_din_n2: got %h want %h", dac_din, mute_val); end
    checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL ur_valid_n2: got %b want 1", dac_valid); end
    clr_underrun = 1'b1;
    @(negedge clk);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins: got %b want 1", underrun); end
    clr_underrun = 1'b0;
    en = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ur_flush_busy: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ur_idle_busy: got %b want 0", busy); end
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL ur_idle_valid: got %b want 0", dac_valid); end
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b want 0", underrun); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 4; i++) begin
      s_data  = 16'h0A01 + 16'(i);
      s_valid = 1'b1;
      @(negedge clk);
      checks++; if (fifo_level !== 3'(i + 1)) begin errors++; $display("FAIL bp_level i=%0d: got %0d want %0d", i, fifo_level, i + 1); end
      checks++; if (s_ready !== (i < 3)) begin errors++; $display("FAIL bp_ready i=%0d: got %b want %b", i, s_ready, (i < 3)); end
    end
    s_data = 16'h0A05;
    @(negedge clk);
    @(negedge clk);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level_held: got %0d want 4", fifo_level); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_held: got %b want 0", s_ready); end
    s_valid = 1'b0;
    div_cfg = 8'd0; osr_cfg = 8'd0;
    en = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid n=%0d: got %b want 1", n, dac_valid); end
      checks++; if (dac_din !== 16'h0A00 + 16'(n)) begin errors++; $display("FAIL bp_drain_din n=%0d: got %h want %h", n, dac_din, 16'h0A00 + 16'(n)); end
      if (n == 1) begin
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b want 1", s_ready); end
      end
    end
    en = 1'b0;
    @(negedge clk);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL bp_underrun: got %b want 1", underrun); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", busy); end
    clr_underrun = 1'b1;
    @(negedge clk);
    clr_underrun = 1'b0;
  endtask

  task automatic test_stop_resume;
    logic exp_v;
    logic [15:0] exp_d;
    div_cfg = 8'd1; osr_cfg = 8'd3;
    push_word(16'h1111);
    push_word(16'h2222);
    en = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      exp_v = (n % 2 == 0) && (n <= 8);
      checks++; if (dac_valid !== exp_v) begin errors++; $display("FAIL stop_valid n=%0d: got %b want %b", n, dac_valid, exp_v); end
      if (exp_v) begin
        checks++; if (dac_din !== 16'h1111) begin errors++; $display("FAIL stop_din n=%0d: got %h want 1111", n, dac_din); end
      end
      checks++; if (busy !== (n <= 8)) begin errors++; $display("FAIL stop_busy n=%0d: got %b want %b", n, busy, (n <= 8)); end
      if (n == 2) en = 1'b0;
    end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL stop_no_pop: got %0d want 1", fifo_level); end
    push_word(16'h3333);
    en = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      exp_v = (n % 2 == 0) && (n <= 16);
      exp_d = (n <= 8) ? 16'h2222 : 16'h3333;
      checks++; if (dac_valid !== exp_v) begin errors++; $display("FAIL resume_valid n=%0d: got %b want %b", n, dac_valid, exp_v); end
      if (exp_v) begin
        checks++; if (dac_din !== exp_d) begin errors++; $display("FAIL resume_din n=%0d: got %h want %h", n, dac_din, exp_d); end
      end
      checks++; if (busy !== (n <= 16)) begin errors++; $display("FAIL resume_busy n=%0d: got %b want %b", n, busy, (n <= 16)); end
      if (n == 2)  en = 1'b0;
      if (n == 3)  en = 1'b1;
      if (n == 10) en = 1'b0;
    end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL resume_underrun: got %b want 0", underrun); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL resume_level: got %0d want 0", fifo_level); end
  endtask

  task automatic test_config_latch;
    logic exp_v;
    logic [15:0] exp_d;
    div_cfg = 8'd3; osr_cfg = 8'd0;
    push_word(16'h4444);
    push_word(16'h5555);
    en = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      exp_v = (n % 4 == 0) && (n <= 8);
      exp_d = (n <= 4) ? 16'h4444 : 16'h5555;
      checks++; if (dac_valid !== exp_v) begin errors++; $display("FAIL cfg_valid n=%0d: got %b want %b", n, dac_valid, exp_v); end
      if (exp_v) begin
        checks++; if (dac_din !== exp_d) begin errors++; $display("FAIL cfg_din n=%0d: got %h want %h", n, dac_din, exp_d); end
      end
      checks++; if (busy !== (n <= 8)) begin errors++; $display("FAIL cfg_busy n=%0d: got %b want %b", n, busy, (n <= 8)); end
      if (n == 1) div_cfg = 8'd0;
      if (n == 5) en = 1'b0;
    end
    osr_cfg = 8'd1;
    push_word(16'h6666);
    en = 1'b1;
    @(negedge clk);
    checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL cfg_reentry_valid_n1: got %b want 1", dac_valid); end
    checks++; if (dac_din !== 16'h6666) begin errors++; $display("FAIL cfg_reentry_din: got %h want 6666", dac_din); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL cfg_reentry_valid_n2: got %b want 1", dac_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_reentry_idle: got %b want 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL cfg_reentry_underrun: got %b want 0", underrun); end
  endtask

  task automatic test_async_reset;
    div_cfg = 8'd1; osr_cfg = 8'd1;
    push_word(16'h7777);
    push_word(16'h1234);
    en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b want 1", dac_valid); end
    checks++; if (dac_din !== 16'h7777) begin errors++; $display("FAIL ar_pre_din: got %h want 7777", dac_din); end
    #2 rst = 1'b1;
    #1;
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", dac_valid); end
    checks++; if (dac_din !== 16'h0000) begin errors++; $display("FAIL ar_din: got %h want 0000", dac_din); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ar_level: got %0d want 0", fifo_level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b want 0", busy); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ar_s_ready: got %b want 1", s_ready); end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_post_busy: got %b want 0", busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ar_post_level: got %0d want 0", fifo_level); end
  endtask

  initial begin
`ifdef SDM_OSR_UNDERRUN_MUTE_EN
    mute_val = 16'h0000;
`else
    mute_val = 16'h7FFF;
`endif
    rst = 1'b1; en = 1'b0; osr_cfg = 8'd0; div_cfg = 8'd0;
    s_valid = 1'b0; s_data = 16'h0000; clr_underrun = 1'b0;
    test_reset();
    test_basic();
    test_underrun();
    test_backpressure();
    test_stop_resume();
    test_config_latch();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdm_osr_ctrl.md
Name: sdm_osr_ctrl

Overview:
- Oversampling sequencer for the first-order SDM DAC datapath.
- Accepts PCM samples from upstream over a valid/ready handshake and buffers them in a small FIFO.
- Generates the DAC's single-cycle sample strobe at a programmable rate, presenting each sample for a programmable number of strobes (the oversampling ratio).
- Handles start, stop and underrun so the modulator always sees a well-defined input stream.

Parameters:
- DATA_W, 16, PCM sample width (matches DAC input width).
- OSR_W, 8, width of oversampling-ratio config; ratio = osr_cfg+1.
- DIV_W, 8, width of strobe clock-divider config; strobe period = div_cfg+1 clocks.
- FIFO_DEPTH, 4, sample FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  run request; level-sensitive.
- osr_cfg  in  OSR_W  strobes per sample minus 1.
- div_cfg  in  DIV_W  clocks per strobe minus 1.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  FIFO can accept; equals not-full.
- s_data  in  DATA_W  upstream signed sample.
- dac_valid  out  1  one-cycle strobe to DAC valid input.
- dac_din  out  DATA_W  sample presented to DAC; stable between pops.
- busy  out  1  FSM not IDLE.
- underrun  out  1  sticky underrun flag.
- clr_underrun  in  1  clears underrun.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - dac_valid=0, dac_din=0, busy=0, underrun=0, fifo_level=0.
  - s_ready=1; FIFO empty; FSM=IDLE; all counters 0.
- FIFO:
  - A push occurs when s_valid and s_ready are both high.
  - A pop occurs only on a sample boundary in RUN.
  - A simultaneous push and pop when full is allowed; level is unchanged.
  - s_ready is combinational from the full flag; s_data is ignored when s_ready=0.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - dac_valid=0 and dac_din holds its last value.
  - When en=1 and the FIFO is not empty:
    - latch osr_cfg and div_cfg into internal registers;
    - pop the head sample into dac_din;
    - clear the divider and OSR counters;
    - go to RUN.
  - Config changes are ignored outside IDLE.
- RUN:
  - The divider counts 0..div_lat and wraps.
  - dac_valid=1 in the cycle the divider equals div_lat.
  - Latency: the first strobe comes div_lat+1 clocks after entering RUN. If div_lat=0, a strobe is issued every clock.
  - The OSR counter increments on each strobe.
  - The sample boundary is the strobe at which the OSR counter equals osr_lat:
    - the OSR counter wraps to 0;
    - the next FIFO head is loaded into dac_din in the same cycle (visible from the next strobe onward).
  - If the FIFO is empty at a boundary:
    - set underrun;
    - keep the current dac_din (repeat);
    - strobing continues.
  - The underrun check also catches a push arriving in the boundary cycle: that sample is not bypassed and is used at the next boundary.
  - If en=0 at any cycle, go to FLUSH.
- FLUSH:
  - Continue strobing until the current sample's boundary strobe; no pop occurs at that boundary.
  - Then go to IDLE.
  - If en returns to 1 during FLUSH, go back to RUN without disturbing the counters.
- underrun:
  - Set by an underrun event and cleared by clr_underrun.
  - If both occur in the same cycle, set wins.
- busy = (state != IDLE).
- Reset mid-operation: immediately returns all state to the reset values; FIFO contents are discarded.

Optional Feature:
- Macro: SDM_OSR_UNDERRUN_MUTE_EN.
- When defined: at an underrun boundary, dac_din is loaded with 0 (mid-scale) instead of repeating the last sample. It stays 0 until a real sample is popped at a later boundary.
- When undefined: the last sample is repeated, as described in Behaviour.
- The underrun flag behaves the same in both builds.

Decomposition:
- Package sdm_pkg:
  - state enum type sdm_osr_state_t {IDLE, RUN, FLUSH};
  - localparam SDM_DATA_W=16;
  - shared between the DAC and the controller.
- Sub-module sdm_sample_fifo:
  - synchronous FIFO with push, pop, full, empty, level;
  - parameterised by DATA_W and FIFO_DEPTH;
  - same clk/rst.
- The FSM and counters stay in sdm_osr_ctrl.

Test Plan:
- Basic run:
  - Stimulus: div_cfg=3, osr_cfg=1; push samples 0x1000, 0x2000; assert en.
  - Response: strobes every 4 clocks; dac_din=0x1000 for strobes 1-2 and 0x2000 for strobes 3-4; first strobe 4 clocks after RUN entry.
- Underrun:
  - Stimulus: push 1 sample 0x7FFF; run with osr_cfg=0.
  - Response: underrun=1 at the 1st boundary; dac_din stays 0x7FFF (default build) or becomes 0x0000 (mute build).
- Full FIFO backpressure:
  - Stimulus: FIFO_DEPTH=4; push 5 samples while in IDLE.
  - Response: s_ready=0 after 4 pushes; fifo_level=4; the 5th sample is held upstream.
- Stop and resume:
  - Stimulus: osr_cfg=3; deassert en after strobe 1 of a sample.
  - Response: strobes 2-4 are still issued; no pop; busy falls the cycle after the 4th strobe. Re-asserting en during FLUSH continues without a gap.
- Config latch:
  - Stimulus: change div_cfg from 3 to 0 during RUN.
  - Response: strobe period stays 4 clocks until IDLE and re-entry.
- Asynchronous reset mid-RUN:
  - Stimulus: assert rst during RUN.
  - Response: dac_valid=0, dac_din=0, fifo_level=0, busy=0 immediately, with no dependence on a clock edge.
